idex_register: RTL and testbench
================================

# idex_register

ID/EX pipeline register for the five-stage core. Captures decoded operands and control from ID on each pipeline advance and holds them for EX. It computes the load-use stall, injects bubbles on flush or load-use, and bypasses same-cycle write-back data into captured operands. Its registered `idex_*` outputs drive the EX operand muxes and the forwarding unit's rs/rt inputs.

## Interface
Parameters:
- none; widths are fixed by the core ISA: word 32, register index 5, aluop 4.

Ports:
- `CLK` in 1: core clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `en` in 1: pipeline advance.
- `flush` in 1: squash the ID instruction (taken branch or jump).
- `id_pc4` in 32: PC+4 of the ID instruction.
- `id_rdat1`, `id_rdat2` in 32: register-file read data.
- `id_imm` in 32: extended immediate.
- `id_shamt` in 5: shift amount.
- `id_rs`, `id_rt`, `id_rd` in 5 each: rs, rt and the selected destination register.
- `id_aluop` in 4: ALU operation.
- `id_alusrc`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_jal`, `id_halt` in 1 each: decoded controls.
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_data` in 32: write-back port, same cycle.
- `idex_*` out: registered copies of every `id_*` field, same widths.
- `idex_valid` out 1: the EX slot holds a real instruction.
- `load_use_stall` out 1: combinational; ID and IF must hold.

## Operation
- `load_use_stall = idex_valid & idex_memread & (idex_rd != 0) & ((idex_rd == id_rs) | (idex_rd == id_rt))`.
- Bubble means: `idex_valid=0`; `idex_regwrite`, `idex_memread`, `idex_memwrite`, `idex_memtoreg`, `idex_jal` and `idex_halt` all 0; data, index and aluop fields also 0.
- Per-edge priority:
  - `RST` loads a bubble and clears the sticky halt.
  - Else `en & (flush | load_use_stall)` loads a bubble.
  - Else `en` captures all `id_*` fields and sets `idex_valid=1`.
  - Else (`!en`) all fields hold, including under `flush`; flush is qualified by `en`.
- Write-back bypass on capture:
  - If `wb_regwrite & (wb_rd != 0) & (wb_rd == id_rs)`, then `idex_rdat1 <= wb_data`. Same rule for rt into `idex_rdat2`.
  - Both may hit at once when rs == rt.
  - Register 0 is never bypassed.
- Sticky halt: once a captured `idex_halt=1`, it stays 1 regardless of `en` or `flush` until `RST`. Other fields keep normal behaviour.
- No arithmetic; all fields pass through at full width with no truncation.

## Timing
- Latency: one cycle from ID inputs to `idex_*` outputs on an `en` edge.
- `load_use_stall` has zero latency, derived from the current `idex_*` and current `id_rs`/`id_rt`. A single load-use case asserts it for exactly one `en` cycle, because the bubble then clears `idex_memread`.
- Reset value of every output is 0. `load_use_stall` is 0 after reset.
- `RST` asserted mid-stream wins over `en` and `flush` on the same edge.
- `en=0` for N cycles: outputs are frozen for N cycles. `load_use_stall` may remain asserted during that time.

## Test plan
- Reset, then capture:
  - Hold `RST` 2 cycles: all outputs are 0.
  - Release, with `en=1`, `id_rs=3`, `id_rdat1=0x1234`, `id_regwrite=1`: next edge gives `idex_rs=3`, `idex_rdat1=0x1234`, `idex_regwrite=1`, `idex_valid=1`.
- Load-use:
  - Capture `lw` with `id_memread=1`, `id_rd=5`.
  - Next, ID presents `id_rt=5` with `en=1`: `load_use_stall=1`.
  - Following edge gives a bubble (`idex_valid=0`) and `load_use_stall` returns to 0.
  - Repeat with `id_rd=0`: no stall.
- Flush vs enable:
  - `flush=1`, `en=0`: all outputs hold.
  - `flush=1`, `en=1`: bubble, with `idex_memwrite=0` even though `id_memwrite=1`.
- Write-back bypass:
  - `id_rs=id_rt=7`, `id_rdat1=id_rdat2=0xAAAA`, `wb_regwrite=1`, `wb_rd=7`, `wb_data=0x5555`, `en=1`: both `idex_rdat` outputs are 0x5555.
  - Same stimulus with `wb_rd=0`: both remain 0xAAAA.
- Stall hold: capture a value, then `en=0` for 4 cycles while changing every `id_*` input: outputs unchanged.
- Sticky halt and reset:
  - Capture `id_halt=1`, then `flush` with `en=1`: `idex_halt` stays 1.
  - Assert `RST`: `idex_halt=0`.

Source files
------------

// File: rtl/idex_register_if.sv
// ID/EX pipeline register bus: decoded ID fields, write-back port, EX-side outputs.
interface idex_register_if;
   logic        en;
   logic        flush;
   logic [31:0] id_pc4, id_rdat1, id_rdat2, id_imm;
   logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
   logic [3:0]  id_aluop;
   logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_jal, id_halt;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] idex_pc4, idex_rdat1, idex_rdat2, idex_imm;
   logic [4:0]  idex_shamt, idex_rs, idex_rt, idex_rd;
   logic [3:0]  idex_aluop;
   logic        idex_alusrc, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_jal, idex_halt;
   logic        idex_valid;
   logic        load_use_stall;

   // ID stage side: drives decoded fields, sees the stall
   modport master (
      output en, flush, id_pc4, id_rdat1, id_rdat2, id_imm, id_shamt, id_rs, id_rt, id_rd,
             id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_jal,
             id_halt, wb_regwrite, wb_rd, wb_data,
      input  idex_pc4, idex_rdat1, idex_rdat2, idex_imm, idex_shamt, idex_rs, idex_rt, idex_rd,
             idex_aluop, idex_alusrc, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
             idex_jal, idex_halt, idex_valid, load_use_stall
   );

   // pipeline register side
   modport slave (
      input  en, flush, id_pc4, id_rdat1, id_rdat2, id_imm, id_shamt, id_rs, id_rt, id_rd,
             id_aluop, id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_jal,
             id_halt, wb_regwrite, wb_rd, wb_data,
      output idex_pc4, idex_rdat1, idex_rdat2, idex_imm, idex_shamt, idex_rs, idex_rt, idex_rd,
             idex_aluop, idex_alusrc, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
             idex_jal, idex_halt, idex_valid, load_use_stall
   );
endinterface

// File: rtl/idex_register.sv
// ID/EX pipeline register: capture on advance, bubble on flush/load-use,
// same-cycle write-back bypass into captured operands, sticky halt.
module idex_register (
   input logic            CLK,
   input logic            RST,
   idex_register_if.slave bus
);
   // every field except halt; a bubble is simply all-zero
   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  aluop;
      logic        alusrc;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
      logic        jal;
   } ex_t;

   ex_t  r_ex;
   ex_t  w_cap;
   logic r_valid;
   logic r_halt;
   logic w_stall;
   logic w_bubble;
   logic w_byp_rs;
   logic w_byp_rt;

   // load in EX whose destination feeds the ID instruction
   assign w_stall  = r_valid & r_ex.memread & (r_ex.rd != 5'd0) &
                     ((r_ex.rd == bus.id_rs) | (r_ex.rd == bus.id_rt));
   assign w_bubble = bus.en & (bus.flush | w_stall);

   // write-back lands this cycle; register 0 never forwards
   assign w_byp_rs = bus.wb_regwrite & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs);
   assign w_byp_rt = bus.wb_regwrite & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rt);

   // assemble the captured bundle with bypassed operands
   always_comb begin
      w_cap.pc4      = bus.id_pc4;
      w_cap.rdat1    = w_byp_rs ? bus.wb_data : bus.id_rdat1;
      w_cap.rdat2    = w_byp_rt ? bus.wb_data : bus.id_rdat2;
      w_cap.imm      = bus.id_imm;
      w_cap.shamt    = bus.id_shamt;
      w_cap.rs       = bus.id_rs;
      w_cap.rt       = bus.id_rt;
      w_cap.rd       = bus.id_rd;
      w_cap.aluop    = bus.id_aluop;
      w_cap.alusrc   = bus.id_alusrc;
      w_cap.regwrite = bus.id_regwrite;
      w_cap.memread  = bus.id_memread;
      w_cap.memwrite = bus.id_memwrite;
      w_cap.memtoreg = bus.id_memtoreg;
      w_cap.jal      = bus.id_jal;
   end

   // reset > bubble > capture > hold; halt only ever sets until reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ex    <= '0;
         r_valid <= 1'b0;
         r_halt  <= 1'b0;
      end else if (w_bubble) begin
         r_ex    <= '0;
         r_valid <= 1'b0;
      end else if (bus.en) begin
         r_ex    <= w_cap;
         r_valid <= 1'b1;
         r_halt  <= r_halt | bus.id_halt;
      end
   end

   assign bus.idex_pc4       = r_ex.pc4;
   assign bus.idex_rdat1     = r_ex.rdat1;
   assign bus.idex_rdat2     = r_ex.rdat2;
   assign bus.idex_imm       = r_ex.imm;
   assign bus.idex_shamt     = r_ex.shamt;
   assign bus.idex_rs        = r_ex.rs;
   assign bus.idex_rt        = r_ex.rt;
   assign bus.idex_rd        = r_ex.rd;
   assign bus.idex_aluop     = r_ex.aluop;
   assign bus.idex_alusrc    = r_ex.alusrc;
   assign bus.idex_regwrite  = r_ex.regwrite;
   assign bus.idex_memread   = r_ex.memread;
   assign bus.idex_memwrite  = r_ex.memwrite;
   assign bus.idex_memtoreg  = r_ex.memtoreg;
   assign bus.idex_jal       = r_ex.jal;
   assign bus.idex_halt      = r_halt;
   assign bus.idex_valid     = r_valid;
   assign bus.load_use_stall = w_stall;
endmodule

// File: tb/tb_idex_register.sv
// Directed bench for idex_register: stimulus pushes expected outputs into a
// scoreboard queue tagged with a cycle; a negedge monitor pops and compares.
module tb_idex_register;
   logic CLK = 1'b0;
   logic RST;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   idex_register_if bus ();
   idex_register dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct packed {
      logic        rst, en, flush;
      logic [31:0] pc4, rdat1, rdat2, imm;
      logic [4:0]  shamt, rs, rt, rd;
      logic [3:0]  aluop;
      logic        alusrc, regwrite, memread, memwrite, memtoreg, jal, halt;
      logic        wb_regwrite;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } in_t;

   typedef struct packed {
      logic [31:0] pc4, rdat1, rdat2, imm;
      logic [4:0]  shamt, rs, rt, rd;
      logic [3:0]  aluop;
      logic        alusrc, regwrite, memread, memwrite, memtoreg, jal, halt;
      logic        valid, stall;
   } out_t;

   typedef struct {
      int    cyc;
      string name;
      out_t  e;
   } exp_t;

   exp_t q[$];
   out_t act;

   always_comb begin
      act          = '0;
      act.pc4      = bus.idex_pc4;
      act.rdat1    = bus.idex_rdat1;
      act.rdat2    = bus.idex_rdat2;
      act.imm      = bus.idex_imm;
      act.shamt    = bus.idex_shamt;
      act.rs       = bus.idex_rs;
      act.rt       = bus.idex_rt;
      act.rd       = bus.idex_rd;
      act.aluop    = bus.idex_aluop;
      act.alusrc   = bus.idex_alusrc;
      act.regwrite = bus.idex_regwrite;
      act.memread  = bus.idex_memread;
      act.memwrite = bus.idex_memwrite;
      act.memtoreg = bus.idex_memtoreg;
      act.jal      = bus.idex_jal;
      act.halt     = bus.idex_halt;
      act.valid    = bus.idex_valid;
      act.stall    = bus.load_use_stall;
   end

   // monitor: compare every entry due this cycle
   always @(negedge CLK) begin
      while (q.size() != 0 && q[0].cyc <= cyc) begin
         exp_t x;
         x = q.pop_front();
         n_chk++;
         if (x.cyc != cyc)
            $display("FAIL %s: entry for cycle %0d not checked in time (now %0d)", x.name, x.cyc, cyc);
         else if (act !== x.e)
            $display("FAIL %s: got %h expected %h", x.name, act, x.e);
         else
            n_pass++;
      end
   end

   task automatic apply(input in_t v);
      @(posedge CLK);
      #1;
      RST             = v.rst;
      bus.en          = v.en;
      bus.flush       = v.flush;
      bus.id_pc4      = v.pc4;
      bus.id_rdat1    = v.rdat1;
      bus.id_rdat2    = v.rdat2;
      bus.id_imm      = v.imm;
      bus.id_shamt    = v.shamt;
      bus.id_rs       = v.rs;
      bus.id_rt       = v.rt;
      bus.id_rd       = v.rd;
      bus.id_aluop    = v.aluop;
      bus.id_alusrc   = v.alusrc;
      bus.id_regwrite = v.regwrite;
      bus.id_memread  = v.memread;
      bus.id_memwrite = v.memwrite;
      bus.id_memtoreg = v.memtoreg;
      bus.id_jal      = v.jal;
      bus.id_halt     = v.halt;
      bus.wb_regwrite = v.wb_regwrite;
      bus.wb_rd       = v.wb_rd;
      bus.wb_data     = v.wb_data;
   endtask

   // expected outputs at this cycle's negedge
   task automatic expect_now(input string name, input out_t e);
      exp_t x;
      x.cyc  = cyc;
      x.name = name;
      x.e    = e;
      q.push_back(x);
   endtask

   // plain field copy of an ID vector as it appears once captured
   function automatic out_t cap(input in_t v);
      out_t o;
      o          = '0;
      o.pc4      = v.pc4;   o.rdat1 = v.rdat1; o.rdat2 = v.rdat2; o.imm = v.imm;
      o.shamt    = v.shamt; o.rs = v.rs; o.rt = v.rt; o.rd = v.rd; o.aluop = v.aluop;
      o.alusrc   = v.alusrc; o.regwrite = v.regwrite; o.memread = v.memread;
      o.memwrite = v.memwrite; o.memtoreg = v.memtoreg; o.jal = v.jal; o.halt = v.halt;
      o.valid    = 1'b1;
      return o;
   endfunction

   initial begin
      repeat (5000) @(posedge CLK);
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      in_t  z, v, lw, u, un, lw0, u0, f0, f1, b, h, x, hh, fl;
      out_t e;
      z = '0;

      // reset for two edges
      v = z; v.rst = 1'b1;
      apply(v);
      apply(v);
      apply(z);
      expect_now("reset", '0);

      // first capture
      v = z; v.en = 1'b1; v.rs = 5'd3; v.rdat1 = 32'h1234; v.regwrite = 1'b1;
      apply(v);
      apply(z);
      expect_now("capture", cap(v));

      // load-use: lw r5 then consumer of r5 via rt
      lw = z; lw.en = 1'b1; lw.memread = 1'b1; lw.memtoreg = 1'b1; lw.regwrite = 1'b1;
      lw.rd = 5'd5; lw.rs = 5'd1; lw.rt = 5'd2; lw.imm = 32'h10; lw.pc4 = 32'h100;
      u = z; u.en = 1'b1; u.rs = 5'd6; u.rt = 5'd5; u.rd = 5'd9; u.pc4 = 32'h104;
      u.rdat1 = 32'hCAFE_0001; u.aluop = 4'h3;
      apply(lw);
      apply(u);
      e = cap(lw); e.stall = 1'b1;
      expect_now("lu_stall", e);
      apply(u);
      expect_now("lu_bubble", '0);
      apply(z);
      expect_now("lu_after", cap(u));

      // load to r0 never stalls
      lw0 = lw; lw0.rd = 5'd0;
      u0 = z; u0.en = 1'b1; u0.pc4 = 32'h44;
      apply(lw0);
      apply(u0);
      expect_now("lu_rd0", cap(lw0));
      apply(z);
      expect_now("lu_rd0_cap", cap(u0));

      // flush without advance holds, with advance bubbles
      f0 = z; f0.flush = 1'b1; f0.memwrite = 1'b1; f0.pc4 = 32'hDEAD_BEEF; f0.rs = 5'd11;
      f1 = f0; f1.en = 1'b1; f1.regwrite = 1'b1;
      apply(f0);
      apply(f0);
      expect_now("flush_noen", cap(u0));
      apply(f1);
      apply(z);
      expect_now("flush_bubble", '0);

      // write-back bypass into both operands
      b = z; b.en = 1'b1; b.rs = 5'd7; b.rt = 5'd7; b.rdat1 = 32'hAAAA; b.rdat2 = 32'hAAAA;
      b.wb_regwrite = 1'b1; b.wb_rd = 5'd7; b.wb_data = 32'h5555;
      apply(b);
      apply(z);
      e = cap(b); e.rdat1 = 32'h5555; e.rdat2 = 32'h5555;
      expect_now("bypass", e);
      v = b; v.wb_rd = 5'd0;
      apply(v);
      apply(z);
      expect_now("bypass_r0", cap(v));
      v = b; v.rt = 5'd8;
      apply(v);
      apply(z);
      e = cap(v); e.rdat1 = 32'h5555;
      expect_now("bypass_rs", e);

      // en low for four edges while every input churns
      h = z; h.en = 1'b1; h.pc4 = 32'h8000_0004; h.rdat1 = 32'h1111_2222; h.rdat2 = 32'h3333_4444;
      h.imm = 32'hFFFF_FFF0; h.shamt = 5'd31; h.rs = 5'd12; h.rt = 5'd13; h.rd = 5'd14;
      h.aluop = 4'hF; h.alusrc = 1'b1; h.regwrite = 1'b1; h.memwrite = 1'b1; h.jal = 1'b1;
      apply(h);
      for (int i = 0; i < 5; i++) begin
         x = '1; x.rst = 1'b0; x.en = 1'b0; x.flush = i[0];
         x.pc4 = 32'hF000_0000 + i; x.rs = 5'(i); x.rt = 5'd14; x.halt = 1'b0;
         apply(x);
         if (i > 0) expect_now("hold", cap(h));
      end

      // stall stays up while frozen, then releases into a bubble
      un = u; un.en = 1'b0;
      apply(lw);
      apply(un);
      e = cap(lw); e.stall = 1'b1;
      expect_now("stall_frozen", e);
      apply(un);
      expect_now("stall_hold", e);
      apply(u);
      apply(z);
      expect_now("stall_release", '0);

      // sticky halt survives flush and later captures, cleared by reset
      hh = z; hh.en = 1'b1; hh.halt = 1'b1; hh.pc4 = 32'h200; hh.rd = 5'd4; hh.regwrite = 1'b1;
      fl = z; fl.en = 1'b1; fl.flush = 1'b1;
      apply(hh);
      apply(fl);
      expect_now("halt_cap", cap(hh));
      apply(z);
      e = '0; e.halt = 1'b1;
      expect_now("halt_sticky", e);
      v = z; v.en = 1'b1; v.pc4 = 32'h300; v.rs = 5'd2;
      apply(v);
      apply(z);
      e = cap(v); e.halt = 1'b1;
      expect_now("halt_sticky2", e);
      v = h; v.rst = 1'b1; v.flush = 1'b1;
      apply(v);
      apply(z);
      expect_now("halt_rst", '0);

      repeat (2) @(posedge CLK);
      #1;
      if (q.size() != 0) begin
         $display("FAIL scoreboard: %0d entries left unchecked, expected 0", q.size());
         n_chk += q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
